// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default PC width, reset PC, instruction width, fetch credit depth, fetch FSM states.
package if_fetch_ctrl_pkg;

  localparam int          FETCH_XLEN     = 64;
  localparam logic [63:0] FETCH_RESET_PC = 64'h0;
  localparam int          INSTR_W        = 32;
  localparam int          FETCH_DEPTH    = 2;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bundle of the fetch unit's handshakes: redirect in, imem request/response, IF/ID output.
// Latency: n/a (wires only).
// Backpressure: imem_req_ready stalls requests, out_ready stalls delivery; responses cannot be stalled.
// Modports: master = fetch unit side, slave = surrounding core / memory / testbench side.
interface if_fetch_ctrl_if
  #(parameter int XLEN = if_fetch_ctrl_pkg::FETCH_XLEN);
  import if_fetch_ctrl_pkg::*;

  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               imem_req_valid;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_req_ready;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               out_valid;
  logic [XLEN-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output out_valid, out_pc, out_instr,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  out_valid, out_pc, out_instr,
    output out_ready
  );

endinterface

// File: rtl/if_fetch_ctrl_fetch_fifo.sv
// Small synchronous FIFO with fall-through head (pop_dat valid whenever !empty).
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: push is dropped when full unless a pop frees a slot the same cycle; flush empties it.
// Ports: clk, rst (sync, high), flush, push/push_dat, pop/pop_dat, count, full, empty.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];
  assign count   = cnt;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues imem word requests, pairs in-order responses with PCs.
// Latency: response in cycle t is presented on out_* in cycle t+1; 1 instr/cycle with 1-cycle imem.
// Backpressure: at most DEPTH fetches in flight or buffered; out_ready low stops new requests.
// Ports: clk, rst (sync, high), bus (master): redirect in, imem req/resp, {out_pc,out_instr} to IF/ID.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int              XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC),
  parameter int              DEPTH    = FETCH_DEPTH
) (
  input logic             clk,
  input logic             rst,
  if_fetch_ctrl_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = XLEN + INSTR_W;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic            redir, resp_ok, resp_drop, resp_keep;
  logic            req_vld, req_fire, out_vld, out_pop, credit_ok;
  logic [XLEN-1:0] pcq_head;
  logic [CW-1:0]   pcq_count, outq_count;
  logic            pcq_full, pcq_empty, outq_full, outq_empty;
  logic [OW-1:0]   outq_head;

  assign redir = bus.redirect_valid;
  // A response with nothing outstanding is a leftover from before a reset.
  assign resp_ok   = bus.imem_resp_valid && (inflight_q != '0);
  // Responses landing in a redirect cycle belong to the abandoned path.
  assign resp_drop = resp_ok && (redir || (discard_q != '0));
  assign resp_keep = resp_ok && !resp_drop;

  // IF/ID is being flushed by the same redirect, so nothing is offered that cycle.
  assign out_vld = !outq_empty && !redir;
  assign out_pop = out_vld && bus.out_ready;

  // Credits count in-flight plus buffered fetches. A slot being popped this cycle is
  // reused immediately; without that, a 1-cycle imem could not sustain 1 instr/cycle.
  assign credit_ok = (int'(inflight_q) + int'(outq_count) - int'(out_pop)) < DEPTH;

  assign req_fire   = req_vld && bus.imem_req_ready;
  assign inflight_d = inflight_q + CW'(req_fire) - CW'(resp_ok);

  // After a redirect every outstanding fetch is stale; a request cannot fire that cycle.
  always_comb begin
    discard_d = discard_q;
    if (redir)          discard_d = inflight_d;
    else if (resp_drop) discard_d = discard_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      if (redir)         pc_q <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      else if (req_fire) pc_q <= pc_q + XLEN'(4);
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (redir) begin
      state_d = (inflight_d != '0) ? FLUSH : RUN;
    end else begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = RUN;
        FLUSH:   if (discard_d == '0) state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    req_vld = (state_q == RUN) && !redir && credit_ok;
  end

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = out_vld;
  assign bus.out_pc         = outq_empty ? '0 : outq_head[OW-1:INSTR_W];
  assign bus.out_instr      = outq_empty ? '0 : outq_head[INSTR_W-1:0];

  // Address of every accepted fetch still expected to be delivered.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_q (
    .clk      (clk),
    .rst      (rst),
    .flush    (redir),
    .push     (req_fire),
    .push_dat (pc_q),
    .pop      (resp_keep),
    .pop_dat  (pcq_head),
    .count    (pcq_count),
    .full     (pcq_full),
    .empty    (pcq_empty)
  );

  fetch_fifo #(.WIDTH(OW), .DEPTH(DEPTH)) u_out_q (
    .clk      (clk),
    .rst      (rst),
    .flush    (redir),
    .push     (resp_keep),
    .push_dat ({pcq_head, bus.imem_resp_data}),
    .pop      (out_pop),
    .pop_dat  (outq_head),
    .count    (outq_count),
    .full     (outq_full),
    .empty    (outq_empty)
  );

  a_resp_fits: assert property (@(posedge clk) disable iff (rst)
    !(resp_keep && outq_full))
    else $error("instruction response arrived with output queue full");

  a_pcq_sane: assert property (@(posedge clk) disable iff (rst)
    !(resp_keep && pcq_empty) && !(req_fire && pcq_full) && (pcq_count <= inflight_q))
    else $error("pc queue out of step with in-flight fetches");

  a_late_resp: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_resp_valid && (inflight_q == '0)))
    else $warning("imem response with nothing in flight ignored");

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios followed by a randomized run against a stream model.
// Model: fetch and delivery PCs advance by 4 from RESET_PC or the last redirect target; instr = f(pc).
// The imem model returns accepted requests in order after a random latency.
module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [63:0] RST_PC = 64'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_ctrl_if #(.XLEN(64)) bus ();

  if_fetch_ctrl #(.XLEN(64), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  pend_t       imq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0, accepted = 0, delivered = 0, useful = 0;
  int          p_req_rdy = 100, p_out_rdy = 100, lat_min = 1, lat_max = 1;
  logic [63:0] exp_fetch = RST_PC;
  logic [63:0] exp_deliver = RST_PC;
  bit          expect_first_req = 1'b0;
  bit          expect_empty = 1'b0;
  bit          last_req_vld = 1'b0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, observe 1ns later, account the handshakes
  // that the following rising edge will complete.
  task automatic step(input bit redir, input logic [63:0] tgt);
    bit    resp;
    pend_t p;
    @(negedge clk);
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.imem_req_ready = ($urandom_range(99) < p_req_rdy);
    bus.out_ready      = ($urandom_range(99) < p_out_rdy);
    resp = (imq.size() > 0) && (imq[0].due <= cyc);
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = resp ? mem_word(imq[0].addr) : 32'h0;
    #1;
    if (expect_first_req) begin
      chk("first_req_vld", 64'(bus.imem_req_valid), 64'd1);
      expect_first_req = 1'b0;
    end
    if (expect_empty) begin
      chk("empty_after_redir", 64'(bus.out_valid), 64'd0);
      expect_empty = 1'b0;
    end
    if (redir) begin
      chk("req_vld_in_redir", 64'(bus.imem_req_valid), 64'd0);
      chk("out_vld_in_redir", 64'(bus.out_valid), 64'd0);
    end
    last_req_vld = bus.imem_req_valid;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      chk("req_addr", bus.imem_req_addr, exp_fetch);
      p.addr = bus.imem_req_addr;
      p.due  = cyc + int'($urandom_range(lat_max, lat_min));
      imq.push_back(p);
      exp_fetch += 64'd4;
      accepted++;
      useful++;
    end
    if (resp) void'(imq.pop_front());
    if (bus.out_valid && bus.out_ready) begin
      chk("out_pc", bus.out_pc, exp_deliver);
      chk("out_instr", 64'(bus.out_instr), 64'(mem_word(exp_deliver)));
      exp_deliver += 64'd4;
      delivered++;
      useful--;
    end
    if (bus.imem_req_valid && bus.imem_req_ready)
      chk("credit_limit", 64'((useful <= DEPTH) && (imq.size() <= DEPTH)), 64'd1);
    if (redir) begin
      exp_fetch   = {tgt[63:2], 2'b00};
      exp_deliver = exp_fetch;
      useful      = 0;
    end
    cyc++;
  endtask

  // Hold reset for n edges, check reset outputs, then release and check the BOOT cycle.
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.out_ready       = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_vld", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_req_addr", bus.imem_req_addr, RST_PC);
    chk("rst_out_vld", 64'(bus.out_valid), 64'd0);
    chk("rst_out_pc", bus.out_pc, 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    rst = 1'b0;
    imq.delete();
    exp_fetch   = RST_PC;
    exp_deliver = RST_PC;
    useful      = 0;
    #1;
    chk("boot_no_req", 64'(bus.imem_req_valid), 64'd0);
    cyc++;
    expect_first_req = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0;
    rst = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.out_ready       = 1'b0;

    // Sustained stream: 1-cycle imem, IF/ID always ready.
    p_req_rdy = 100; p_out_rdy = 100; lat_min = 1; lat_max = 1;
    do_reset(3);
    d0 = delivered;
    repeat (30) step(1'b0, 64'h0);
    chk("stream_rate", 64'(delivered - d0), 64'd28);

    // IF/ID stalled: only DEPTH fetches go out, then the stream resumes intact.
    do_reset(2);
    p_out_rdy = 0;
    a0 = accepted;
    repeat (10) step(1'b0, 64'h0);
    chk("stall_req_count", 64'(accepted - a0), 64'(DEPTH));
    chk("stall_req_vld", 64'(last_req_vld), 64'd0);
    p_out_rdy = 100;
    d0 = delivered;
    repeat (20) step(1'b0, 64'h0);
    chk("stall_resume", 64'(delivered - d0), 64'd20);

    // Redirect with two fetches in flight (latency 3) to an unaligned target.
    do_reset(2);
    lat_min = 3; lat_max = 3;
    step(1'b0, 64'h0);
    step(1'b0, 64'h0);
    chk("two_in_flight", 64'(imq.size()), 64'd2);
    step(1'b1, 64'h1003);
    d0 = delivered;
    repeat (15) step(1'b0, 64'h0);
    chk("redir_delivered", 64'((delivered - d0) >= 2), 64'd1);

    // Redirect colliding with a response and a valid output.
    do_reset(2);
    lat_min = 1; lat_max = 1;
    repeat (5) step(1'b0, 64'h0);
    step(1'b1, 64'h2000);
    expect_empty = 1'b1;
    repeat (10) step(1'b0, 64'h0);

    // PC wrap at the top of the address space.
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    d0 = delivered;
    repeat (8) step(1'b0, 64'h0);
    chk("wrap_delivered", 64'((delivered - d0) >= 3), 64'd1);

    // Reset with two fetches in flight.
    lat_min = 3; lat_max = 3;
    step(1'b1, 64'h3000);
    step(1'b0, 64'h0);
    step(1'b0, 64'h0);
    chk("rst_two_in_flight", 64'(imq.size()), 64'd2);
    do_reset(1);
    repeat (12) step(1'b0, 64'h0);

    // Randomized run: random readiness, latency 1..4, occasional redirects.
    p_req_rdy = 70; p_out_rdy = 75; lat_min = 1; lat_max = 4;
    d0 = delivered;
    repeat (1500) begin
      if ($urandom_range(99) < 4) step(1'b1, {$urandom, $urandom});
      else                        step(1'b0, 64'h0);
    end
    chk("random_progress", 64'((delivered - d0) > 150), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
